// File: rtl/dds_cmd_assembler_if.sv
// Host byte stream in, assembled DDS command out, plus the DDS busy handshake.
// master: byte source and DDS controller side; slave: the command assembler.
// Signal names follow the board-level naming of the DDS controller.
interface dds_cmd_assembler_if #(
    parameter int LENGTH_BIT_COUNT = 3,
    parameter int MAXLENGTH8       = 56
);
    logic [7:0]                  RX_Byte;
    logic                        RX_Byte_Valid;
    logic                        DDS_Busy;
    logic [3:0]                  ChipSelect;
    logic [LENGTH_BIT_COUNT-1:0] DDS_Data_Bytes;
    logic [MAXLENGTH8-1:0]       DDS_Data;
    logic                        DDS_Data_Ready;
    logic                        Cmd_Error;
    logic                        Overrun;

    modport master (
        output RX_Byte, RX_Byte_Valid, DDS_Busy,
        input  ChipSelect, DDS_Data_Bytes, DDS_Data, DDS_Data_Ready, Cmd_Error, Overrun
    );

    modport slave (
        input  RX_Byte, RX_Byte_Valid, DDS_Busy,
        output ChipSelect, DDS_Data_Bytes, DDS_Data, DDS_Data_Ready, Cmd_Error, Overrun
    );
endinterface

// File: rtl/dds_cmd_assembler.sv
// Assembles header + N payload bytes (MSB first) into one DDS command and hands it off.
// Latency: DDS_Data_Ready rises the cycle after the last payload byte (later if DDS_Busy is still high).
// Backpressure: none on the byte stream; bytes arriving while a command is held are dropped and flagged.
module dds_cmd_assembler #(
    parameter int LENGTH_BIT_COUNT = 3,
    parameter int MAXLENGTH        = 7,
    parameter int MAXLENGTH8       = MAXLENGTH * 8,
    parameter int TIMEOUT_CYCLES   = 50000
) (
    input  logic clk50MHz,
    input  logic reset_n,
    dds_cmd_assembler_if.slave bus
);
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] ISSUE   = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [3:0]                  cs_q, cs_d;
    logic [LENGTH_BIT_COUNT-1:0] bytes_q, bytes_d;
    logic [LENGTH_BIT_COUNT-1:0] rem_q, rem_d;
    logic [MAXLENGTH8-1:0]       data_q, data_d;
    logic [GW-1:0]               gap_q, gap_d;
    logic                        rdy_q, rdy_d;
    logic                        err_q, err_d;
    logic                        ovr_q, ovr_d;
    logic                        hdr_ok;

    // Header is usable only with a non-empty target mask, reserved bit clear and a non-zero length.
    assign hdr_ok = (bus.RX_Byte[7:4] != 4'd0) && !bus.RX_Byte[3] &&
                    (bus.RX_Byte[2:0] != 3'd0) && (int'(bus.RX_Byte[2:0]) <= MAXLENGTH);

    // Next-state logic; error/overrun flags default low so they only ever pulse for one cycle.
    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        bytes_d = bytes_q;
        rem_d   = rem_q;
        data_d  = data_q;
        gap_d   = gap_q;
        rdy_d   = rdy_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.RX_Byte_Valid) begin
                    if (hdr_ok) begin
                        cs_d    = bus.RX_Byte[7:4];
                        bytes_d = LENGTH_BIT_COUNT'(bus.RX_Byte[2:0]);
                        rem_d   = LENGTH_BIT_COUNT'(bus.RX_Byte[2:0]);
                        data_d  = '0;
                        gap_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (rem_q == '0) begin
                    // Payload complete but the previous command's busy is still up: hold off.
                    ovr_d = bus.RX_Byte_Valid;
                    if (!bus.DDS_Busy) begin
                        rdy_d   = 1'b1;
                        state_d = ISSUE;
                    end
                end else if (bus.RX_Byte_Valid) begin
                    data_d = {data_q[MAXLENGTH8-9:0], bus.RX_Byte};
                    rem_d  = rem_q - LENGTH_BIT_COUNT'(1);
                    gap_d  = '0;
                    if ((rem_q == LENGTH_BIT_COUNT'(1)) && !bus.DDS_Busy) begin
                        rdy_d   = 1'b1;
                        state_d = ISSUE;
                    end
                end else if (gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ISSUE: begin
                ovr_d = bus.RX_Byte_Valid;
                if (bus.DDS_Busy) begin
                    rdy_d   = 1'b0;
                    state_d = DRAIN;
                end
            end
            default: begin
                // DRAIN: command outputs stay frozen until the controller drops busy.
                ovr_d = bus.RX_Byte_Valid;
                if (!bus.DDS_Busy) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cs_q    <= '0;
            bytes_q <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            gap_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            bytes_q <= bytes_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.ChipSelect     = cs_q;
    assign bus.DDS_Data_Bytes = bytes_q;
    assign bus.DDS_Data       = data_q;
    assign bus.DDS_Data_Ready = rdy_q;
    assign bus.Cmd_Error      = err_q;
    assign bus.Overrun        = ovr_q;
endmodule

// File: tb/tb_dds_cmd_assembler.sv
// Directed bench for the DDS command assembler with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A watchdog-free flow: every wait on the DUT is bounded by a cycle budget.
module tb_dds_cmd_assembler;
    logic clk50MHz = 1'b0;
    logic reset_n  = 1'b0;
    int   errors   = 0;
    int   checks   = 0;
    int   rdy_cnt  = 0;
    int   err_cnt  = 0;
    int   r0, e0, cnt;

    dds_cmd_assembler_if bus_if ();

    dds_cmd_assembler dut (
        .clk50MHz (clk50MHz),
        .reset_n  (reset_n),
        .bus      (bus_if)
    );

    always #10 clk50MHz = ~clk50MHz;

    always @(negedge clk50MHz) begin
        if (bus_if.DDS_Data_Ready) rdy_cnt <= rdy_cnt + 1;
        if (bus_if.Cmd_Error)      err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the byte is captured by the next rising edge.
    task automatic send(input logic [7:0] b);
        bus_if.RX_Byte       = b;
        bus_if.RX_Byte_Valid = 1'b1;
        @(negedge clk50MHz);
        bus_if.RX_Byte_Valid = 1'b0;
    endtask

    // Controller accepts the pending command and then finishes it.
    task automatic release_cmd(input string tag);
        @(negedge clk50MHz);
        bus_if.DDS_Busy = 1'b1;
        @(negedge clk50MHz);
        chk({tag, "_rdy_drop"}, 64'(bus_if.DDS_Data_Ready), 64'd0);
        bus_if.DDS_Busy = 1'b0;
        @(negedge clk50MHz);
    endtask

    initial begin
        bus_if.RX_Byte       = 8'h00;
        bus_if.RX_Byte_Valid = 1'b0;
        bus_if.DDS_Busy      = 1'b0;
        #25;
        chk("rst_cs",    64'(bus_if.ChipSelect),     64'd0);
        chk("rst_bytes", 64'(bus_if.DDS_Data_Bytes), 64'd0);
        chk("rst_data",  64'(bus_if.DDS_Data),       64'd0);
        chk("rst_rdy",   64'(bus_if.DDS_Data_Ready), 64'd0);
        chk("rst_err",   64'(bus_if.Cmd_Error),      64'd0);
        chk("rst_ovr",   64'(bus_if.Overrun),        64'd0);

        // Basic 3-byte command, header in the first cycle after reset release.
        @(negedge clk50MHz);
        reset_n = 1'b1;
        r0 = rdy_cnt;
        send(8'h13);
        chk("b_rdy_early", 64'(bus_if.DDS_Data_Ready), 64'd0);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("b_rdy",   64'(bus_if.DDS_Data_Ready), 64'd1);
        chk("b_cs",    64'(bus_if.ChipSelect),     64'd1);
        chk("b_bytes", 64'(bus_if.DDS_Data_Bytes), 64'd3);
        chk("b_data",  64'(bus_if.DDS_Data),       64'h010203);
        @(negedge clk50MHz);
        chk("b_rdy_hold", 64'(bus_if.DDS_Data_Ready), 64'd1);
        bus_if.DDS_Busy = 1'b1;
        @(negedge clk50MHz);
        chk("b_rdy_off", 64'(bus_if.DDS_Data_Ready), 64'd0);
        repeat (100) @(negedge clk50MHz);
        chk("b_cs_drain",   64'(bus_if.ChipSelect), 64'd1);
        chk("b_data_drain", 64'(bus_if.DDS_Data),   64'h010203);
        chk("b_rdy_cycles", 64'(rdy_cnt - r0),      64'd2);
        bus_if.DDS_Busy = 1'b0;
        @(negedge clk50MHz);

        // Rejected headers: empty mask, reserved bit set, zero length.
        r0 = rdy_cnt;
        e0 = err_cnt;
        send(8'h00);
        chk("hdr00_err", 64'(bus_if.Cmd_Error), 64'd1);
        send(8'h18);
        chk("hdr18_err", 64'(bus_if.Cmd_Error), 64'd1);
        send(8'h20);
        chk("hdr20_err", 64'(bus_if.Cmd_Error), 64'd1);
        @(negedge clk50MHz);
        chk("hdr_err_pulse", 64'(bus_if.Cmd_Error), 64'd0);
        chk("hdr_err_cnt",   64'(err_cnt - e0),     64'd3);
        chk("hdr_no_rdy",    64'(rdy_cnt - r0),     64'd0);

        // Full-length command.
        send(8'h27);
        for (int i = 1; i <= 7; i++) send(8'(i * 8'h11));
        chk("full_rdy",   64'(bus_if.DDS_Data_Ready), 64'd1);
        chk("full_data",  64'(bus_if.DDS_Data),       64'h11223344556677);
        chk("full_cs",    64'(bus_if.ChipSelect),     64'd2);
        chk("full_bytes", 64'(bus_if.DDS_Data_Bytes), 64'd7);
        release_cmd("full");

        // Inter-byte timeout.
        r0 = rdy_cnt;
        e0 = err_cnt;
        send(8'h12);
        send(8'hAB);
        cnt = 0;
        while (!bus_if.Cmd_Error && cnt < 60000) begin
            @(negedge clk50MHz);
            cnt++;
        end
        chk("to_cycles", 64'(cnt), 64'd50000);
        @(negedge clk50MHz);
        chk("to_err_cnt", 64'(err_cnt - e0), 64'd1);
        chk("to_no_rdy",  64'(rdy_cnt - r0), 64'd0);
        send(8'h41);
        send(8'h5A);
        chk("to_next_rdy",  64'(bus_if.DDS_Data_Ready), 64'd1);
        chk("to_next_data", 64'(bus_if.DDS_Data),       64'h5A);
        chk("to_next_cs",   64'(bus_if.ChipSelect),     64'd4);
        release_cmd("to");

        // Byte dropped during DRAIN.
        send(8'h11);
        send(8'h77);
        chk("dr_rdy", 64'(bus_if.DDS_Data_Ready), 64'd1);
        @(negedge clk50MHz);
        bus_if.DDS_Busy = 1'b1;
        @(negedge clk50MHz);
        send(8'h99);
        chk("dr_ovr",   64'(bus_if.Overrun),        64'd1);
        chk("dr_data",  64'(bus_if.DDS_Data),       64'h77);
        chk("dr_cs",    64'(bus_if.ChipSelect),     64'd1);
        chk("dr_bytes", 64'(bus_if.DDS_Data_Bytes), 64'd1);
        chk("dr_rdy0",  64'(bus_if.DDS_Data_Ready), 64'd0);
        @(negedge clk50MHz);
        chk("dr_ovr_pulse", 64'(bus_if.Overrun), 64'd0);
        bus_if.DDS_Busy = 1'b0;
        @(negedge clk50MHz);
        send(8'h21);
        send(8'h33);
        chk("dr_next_rdy",  64'(bus_if.DDS_Data_Ready), 64'd1);
        chk("dr_next_data", 64'(bus_if.DDS_Data),       64'h33);
        chk("dr_next_cs",   64'(bus_if.ChipSelect),     64'd2);
        release_cmd("dr");

        // Busy still high when the payload completes: issue waits for it to fall.
        bus_if.DDS_Busy = 1'b1;
        send(8'h81);
        send(8'h44);
        chk("lb_rdy_wait0", 64'(bus_if.DDS_Data_Ready), 64'd0);
        @(negedge clk50MHz);
        chk("lb_rdy_wait1", 64'(bus_if.DDS_Data_Ready), 64'd0);
        bus_if.DDS_Busy = 1'b0;
        @(negedge clk50MHz);
        chk("lb_rdy",  64'(bus_if.DDS_Data_Ready), 64'd1);
        chk("lb_data", 64'(bus_if.DDS_Data),       64'h44);
        chk("lb_cs",   64'(bus_if.ChipSelect),     64'd8);
        release_cmd("lb");

        // Reset in the middle of a command.
        send(8'h45);
        send(8'h01);
        send(8'h02);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_cs",    64'(bus_if.ChipSelect),     64'd0);
        chk("mr_bytes", 64'(bus_if.DDS_Data_Bytes), 64'd0);
        chk("mr_data",  64'(bus_if.DDS_Data),       64'd0);
        chk("mr_rdy",   64'(bus_if.DDS_Data_Ready), 64'd0);
        @(negedge clk50MHz);
        reset_n = 1'b1;
        send(8'h31);
        chk("mr_rdy_after", 64'(bus_if.DDS_Data_Ready), 64'd0);
        send(8'hAA);
        chk("mr_new_rdy",   64'(bus_if.DDS_Data_Ready), 64'd1);
        chk("mr_new_data",  64'(bus_if.DDS_Data),       64'hAA);
        chk("mr_new_cs",    64'(bus_if.ChipSelect),     64'd3);
        chk("mr_new_bytes", 64'(bus_if.DDS_Data_Bytes), 64'd1);
        release_cmd("mr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
